// File: rtl/accel_pkg.sv
// accel_pkg: activation codes and lane indexing shared by the scheduler, datapath and layer controller.
package accel_pkg;
  localparam int ACT_W  = 2;
  localparam int LANE_W = 1;
  typedef enum logic [ACT_W-1:0] {
    ACT_LINEAR = 2'b00,
    ACT_RELU   = 2'b01,
    ACT_TANH   = 2'b10
  } act_e;
  typedef logic [LANE_W-1:0] lane_t;
endpackage

// File: rtl/act_sched_fifo.sv
// act_sched_fifo: per-lane result FIFO; head data reads 0 while empty, no fall-through.
module act_sched_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic full, do_wr, do_rd;
  always_comb begin
    count    = wr_ptr_q - rd_ptr_q;
    rd_valid = count != '0;
    full     = wr_ptr_q[AW] != rd_ptr_q[AW] && wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0];
    do_rd    = rd_en && rd_valid;
    do_wr    = wr_en && (!full || do_rd);
    wr_ptr_d = wr_ptr_q + (AW+1)'(do_wr);
    rd_ptr_d = rd_ptr_q + (AW+1)'(do_rd);
    rd_data  = rd_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  always_ff @(posedge clk)
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
endmodule

// File: rtl/activation_scheduler.sv
// activation_scheduler: round-robin, credit-gated sharing of one activation datapath by two lanes,
// with tagged in-flight items routed back into per-lane output FIFOs.
module activation_scheduler
  import accel_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int OUT_WIDTH  = 8,
  parameter int FIFO_DEPTH = 2,
  parameter int AU_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic [ACT_W-1:0]      cfg_act0,
  input  logic [ACT_W-1:0]      cfg_act1,
  output logic [DATA_WIDTH-1:0] au_data_in,
  output logic                  au_valid_in,
  output logic [ACT_W-1:0]      au_act_type,
  input  logic [OUT_WIDTH-1:0]  au_data_out,
  input  logic                  au_valid_out,
  output logic [OUT_WIDTH-1:0]  out0_data,
  output logic                  out0_valid,
  input  logic                  out0_ready,
  output logic [OUT_WIDTH-1:0]  out1_data,
  output logic                  out1_valid,
  input  logic                  out1_ready,
  output logic                  busy
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [CW-1:0] credit0_q, credit0_d, credit1_q, credit1_d, cnt0, cnt1, infl0, infl1;
  logic rr_q, rr_d;
  logic [AU_LATENCY-1:0] tag_valid_q, tag_valid_d;
  lane_t [AU_LATENCY-1:0] tag_lane_q, tag_lane_d;
  logic elig0, elig1, grant0, grant1, pop0, pop1, wr0, wr1, exit_valid;
  lane_t exit_lane;
  // rr_q names the lane that wins when both are eligible
  always_comb begin
    elig0       = rst_n && req0_valid && credit0_q != '0;
    elig1       = rst_n && req1_valid && credit1_q != '0;
    grant0      = elig0 && (!elig1 || !rr_q);
    grant1      = elig1 && (!elig0 || rr_q);
    req0_ready  = grant0;
    req1_ready  = grant1;
    au_valid_in = grant0 || grant1;
    au_data_in  = grant0 ? req0_data : grant1 ? req1_data : '0;
    au_act_type = grant0 ? cfg_act0 : grant1 ? cfg_act1 : '0;
    rr_d        = grant0 ? 1'b1 : grant1 ? 1'b0 : rr_q;
    exit_valid  = tag_valid_q[AU_LATENCY-1];
    exit_lane   = tag_lane_q[AU_LATENCY-1];
    wr0         = au_valid_out && exit_valid && exit_lane == lane_t'(0);
    wr1         = au_valid_out && exit_valid && exit_lane == lane_t'(1);
    pop0        = out0_valid && out0_ready;
    pop1        = out1_valid && out1_ready;
    credit0_d   = grant0 == pop0 ? credit0_q : grant0 ? credit0_q - 1'b1 : credit0_q + 1'b1;
    credit1_d   = grant1 == pop1 ? credit1_q : grant1 ? credit1_q - 1'b1 : credit1_q + 1'b1;
    tag_valid_d = '0;
    tag_lane_d  = '0;
    tag_valid_d[0] = au_valid_in;
    tag_lane_d[0]  = lane_t'(grant1);
    for (int i = 1; i < AU_LATENCY; i++) begin
      tag_valid_d[i] = tag_valid_q[i-1];
      tag_lane_d[i]  = tag_lane_q[i-1];
    end
    infl0 = '0;
    infl1 = '0;
    for (int i = 0; i < AU_LATENCY; i++) begin
      infl0 = infl0 + CW'(tag_valid_q[i] && tag_lane_q[i] == lane_t'(0));
      infl1 = infl1 + CW'(tag_valid_q[i] && tag_lane_q[i] == lane_t'(1));
    end
    busy = |tag_valid_q || out0_valid || out1_valid;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      credit0_q   <= CW'(FIFO_DEPTH);
      credit1_q   <= CW'(FIFO_DEPTH);
      rr_q        <= 1'b0;
      tag_valid_q <= '0;
      tag_lane_q  <= '0;
    end else begin
      credit0_q   <= credit0_d;
      credit1_q   <= credit1_d;
      rr_q        <= rr_d;
      tag_valid_q <= tag_valid_d;
      tag_lane_q  <= tag_lane_d;
    end
  act_sched_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(OUT_WIDTH)) u_fifo0 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr0), .wr_data(au_data_out), .rd_en(out0_ready),
    .rd_data(out0_data), .rd_valid(out0_valid), .count(cnt0)
  );
  act_sched_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(OUT_WIDTH)) u_fifo1 (
    .clk(clk), .rst_n(rst_n), .wr_en(wr1), .wr_data(au_data_out), .rd_en(out1_ready),
    .rd_data(out1_data), .rd_valid(out1_valid), .count(cnt1)
  );
  // A datapath result with no matching tag is dropped; the credit ledger must always balance.
  a_tag_align: assert property (@(posedge clk) disable iff (!rst_n) au_valid_out |-> exit_valid);
  a_ledger0: assert property (@(posedge clk) disable iff (!rst_n)
    int'(credit0_q) + int'(cnt0) + int'(infl0) == FIFO_DEPTH);
  a_ledger1: assert property (@(posedge clk) disable iff (!rst_n)
    int'(credit1_q) + int'(cnt1) + int'(infl1) == FIFO_DEPTH);
endmodule
